// File: rtl/position_neighbor_streamer.sv
// Streams, one neighbor offset per beat, the position of every home cell's neighbor
// in a periodic X_DIM x Y_DIM x Z_DIM grid (half shell: 14 beats, full shell: 27 beats).
package position_neighbor_streamer_pkg;
   localparam int POS_W = 10;

   typedef struct packed {
      logic [POS_W-1:0] x;
      logic [POS_W-1:0] y;
      logic [POS_W-1:0] z;
   } offset_tuple_t;
endpackage

module position_neighbor_streamer
   import position_neighbor_streamer_pkg::*;
#(
   parameter int X_DIM     = 4,
   parameter int Y_DIM     = 4,
   parameter int Z_DIM     = 4,
   parameter int NUM_CELLS = X_DIM * Y_DIM * Z_DIM
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          full_shell,
   input  offset_tuple_t rd_nb_position [NUM_CELLS],
   input  logic          out_ready,
   output logic          out_valid,
   output offset_tuple_t out_position [NUM_CELLS],
   output logic [4:0]    out_nb_idx,
   output logic [2:0]    out_wrap [NUM_CELLS],
   output logic          busy,
   output logic          done
);

   localparam int IDX_W = $clog2(NUM_CELLS);

   if (NUM_CELLS != X_DIM * Y_DIM * Z_DIM) begin : g_bad_num_cells
      $error("NUM_CELLS must equal X_DIM*Y_DIM*Z_DIM");
   end
   if (X_DIM < 3 || X_DIM > 16 || Y_DIM < 3 || Y_DIM > 16 || Z_DIM < 3 || Z_DIM > 16) begin : g_bad_dims
      $error("X_DIM, Y_DIM and Z_DIM must lie in 3..16");
   end

   // Handshake: a beat transfers on a cycle where out_valid and out_ready are both 1;
   // while out_valid=1 and out_ready=0 every beat output holds its value.
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t        state_q, state_d;
   logic          full_q;
   logic [4:0]    n_q;
   logic          start_ok, load, accept, mode_sel;
   logic [4:0]    beat_n, last_n;
   logic          valid_d, busy_d, done_d;
   int            off_x, off_y, off_z, full_k;
   int            cx, cy, cz, nx, ny, nz;
   offset_tuple_t pos_d [NUM_CELLS];
   logic [2:0]    wrap_d [NUM_CELLS];

   // A start in the done cycle is refused so a new sweep only begins from a settled IDLE.
   assign start_ok = (state_q == IDLE) && start && !done;
   assign accept   = out_valid && out_ready;
   assign load     = start_ok || ((state_q == RUN) && (!out_valid || out_ready));
   assign last_n   = full_q ? 5'd26 : 5'd13;
   assign beat_n   = (state_q == IDLE) ? 5'd0 : n_q;
   assign mode_sel = (state_q == IDLE) ? full_shell : full_q;

   // Beat 0 is issued on the start edge itself, so n_q afterwards names the next beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         n_q     <= 5'd0;
         full_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (start_ok) begin
            full_q <= full_shell;
            n_q    <= 5'd1;
         end else if (load) begin
            n_q <= n_q + 5'd1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_ok) state_d = RUN;
         RUN:     if (load && (n_q == last_n)) state_d = DRAIN;
         DRAIN:   if (accept) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      off_x  = 0;
      off_y  = 0;
      off_z  = 0;
      full_k = 0;
      cx     = 0;
      cy     = 0;
      cz     = 0;
      nx     = 0;
      ny     = 0;
      nz     = 0;
      if (mode_sel) begin
         // Full shell walks the 27 offsets lexicographically with the centre (k=13) hoisted to n=0.
         if (beat_n == 5'd0)       full_k = 13;
         else if (beat_n <= 5'd13) full_k = int'(beat_n) - 1;
         else                      full_k = int'(beat_n);
         off_z = full_k / 9 - 1;
         off_y = (full_k / 3) % 3 - 1;
         off_x = full_k % 3 - 1;
      end else begin
         case (beat_n)
            5'd1:    begin off_x =  1; off_y =  0; off_z = 0; end
            5'd2:    begin off_x = -1; off_y =  1; off_z = 0; end
            5'd3:    begin off_x =  0; off_y =  1; off_z = 0; end
            5'd4:    begin off_x =  1; off_y =  1; off_z = 0; end
            5'd5:    begin off_x = -1; off_y = -1; off_z = 1; end
            5'd6:    begin off_x =  0; off_y = -1; off_z = 1; end
            5'd7:    begin off_x =  1; off_y = -1; off_z = 1; end
            5'd8:    begin off_x = -1; off_y =  0; off_z = 1; end
            5'd9:    begin off_x =  0; off_y =  0; off_z = 1; end
            5'd10:   begin off_x =  1; off_y =  0; off_z = 1; end
            5'd11:   begin off_x = -1; off_y =  1; off_z = 1; end
            5'd12:   begin off_x =  0; off_y =  1; off_z = 1; end
            5'd13:   begin off_x =  1; off_y =  1; off_z = 1; end
            default: begin off_x =  0; off_y =  0; off_z = 0; end
         endcase
      end

      for (int h = 0; h < NUM_CELLS; h++) begin
         cx = h % X_DIM;
         cy = (h / X_DIM) % Y_DIM;
         cz = h / (X_DIM * Y_DIM);
         nx = cx + off_x;
         ny = cy + off_y;
         nz = cz + off_z;
         wrap_d[h] = {(nz < 0) || (nz >= Z_DIM), (ny < 0) || (ny >= Y_DIM), (nx < 0) || (nx >= X_DIM)};
         if (nx < 0) nx = nx + X_DIM; else if (nx >= X_DIM) nx = nx - X_DIM;
         if (ny < 0) ny = ny + Y_DIM; else if (ny >= Y_DIM) ny = ny - Y_DIM;
         if (nz < 0) nz = nz + Z_DIM; else if (nz >= Z_DIM) nz = nz - Z_DIM;
         pos_d[h] = rd_nb_position[IDX_W'(nz * X_DIM * Y_DIM + ny * X_DIM + nx)];
      end

      valid_d = load ? 1'b1 : (out_ready ? 1'b0 : out_valid);
      busy_d  = (state_d != IDLE);
      done_d  = (state_q == DRAIN) && accept;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         out_nb_idx <= 5'd0;
         for (int h = 0; h < NUM_CELLS; h++) begin
            out_position[h] <= '0;
            out_wrap[h]     <= 3'b000;
         end
      end else begin
         out_valid <= valid_d;
         busy      <= busy_d;
         done      <= done_d;
         if (load) begin
            out_nb_idx <= beat_n;
            for (int h = 0; h < NUM_CELLS; h++) begin
               out_position[h] <= pos_d[h];
               out_wrap[h]     <= wrap_d[h];
            end
         end
      end
   end

endmodule

// File: tb/tb_position_neighbor_streamer.sv
// Scoreboard bench for position_neighbor_streamer on 4x4x4, 3x3x3 and 5x3x4 grids,
// each grid exercised in turn by its own DUT instance.
module tb_position_neighbor_streamer;
   import position_neighbor_streamer_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int phase  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference neighbor list written straight from the offset tables.
   function automatic void nb_offset(input bit full, input int n, output int dx, output int dy, output int dz);
      int hx[14] = '{0, 1, -1, 0, 1, -1,  0,  1, -1, 0, 1, -1, 0, 1};
      int hy[14] = '{0, 0,  1, 1, 1, -1, -1, -1,  0, 0, 0,  1, 1, 1};
      int hz[14] = '{0, 0,  0, 0, 0,  1,  1,  1,  1, 1, 1,  1, 1, 1};
      int k;
      dx = 0; dy = 0; dz = 0;
      if (!full) begin
         dx = hx[n]; dy = hy[n]; dz = hz[n];
      end else if (n != 0) begin
         k = 0;
         for (int z = -1; z <= 1; z++)
            for (int y = -1; y <= 1; y++)
               for (int x = -1; x <= 1; x++)
                  if (x != 0 || y != 0 || z != 0) begin
                     k++;
                     if (k == n) begin dx = x; dy = y; dz = z; end
                  end
      end
   endfunction

   function automatic int pmod(input int v, input int m);
      return ((v % m) + m) % m;
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_cfg
      localparam int XD = (g == 0) ? 4 : (g == 1) ? 3 : 5;
      localparam int YD = (g == 0) ? 4 : 3;
      localparam int ZD = (g == 0) ? 4 : (g == 1) ? 3 : 4;
      localparam int NC = XD * YD * ZD;

      logic          rst = 1'b1, start = 1'b0, full_shell = 1'b0, out_ready = 1'b1;
      logic          out_valid, busy, done;
      logic [4:0]    out_nb_idx;
      offset_tuple_t rd_pos [NC];
      offset_tuple_t out_position [NC];
      logic [2:0]    out_wrap [NC];
      offset_tuple_t held_pos [NC];
      logic [2:0]    held_wrap [NC];
      logic [4:0]    held_idx;
      logic [37:0]   exp_q[$];
      logic [37:0]   e;
      int            ready_mode = 0, rcnt = 0, beats_seen = 0, done_cnt = 0;
      bit            done_due = 0, held_v = 0, directed = 0, same;

      position_neighbor_streamer #(.X_DIM(XD), .Y_DIM(YD), .Z_DIM(ZD), .NUM_CELLS(NC)) dut (
         .clk(clk), .rst(rst), .start(start), .full_shell(full_shell),
         .rd_nb_position(rd_pos), .out_ready(out_ready), .out_valid(out_valid),
         .out_position(out_position), .out_nb_idx(out_nb_idx), .out_wrap(out_wrap),
         .busy(busy), .done(done)
      );

      always @(posedge clk) begin
         #1;
         case (ready_mode)
            0:       out_ready = 1'b1;
            1:       begin out_ready = ((rcnt % 4) == 0) || ((rcnt % 4) == 3); rcnt++; end
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
      end

      task automatic push_sweep(input bit full);
         int dx, dy, dz, x, y, z, nidx;
         logic [2:0] w;
         for (int n = 0; n < (full ? 27 : 14); n++) begin
            nb_offset(full, n, dx, dy, dz);
            for (int h = 0; h < NC; h++) begin
               x = h % XD; y = (h / XD) % YD; z = h / (XD * YD);
               w[0] = (x + dx < 0) || (x + dx >= XD);
               w[1] = (y + dy < 0) || (y + dy >= YD);
               w[2] = (z + dz < 0) || (z + dz >= ZD);
               nidx = pmod(z + dz, ZD) * XD * YD + pmod(y + dy, YD) * XD + pmod(x + dx, XD);
               exp_q.push_back({5'(n), rd_pos[nidx], w});
            end
         end
      endtask

      task automatic reset_check();
         rst = 1'b1; start = 1'b0; full_shell = 1'b0;
         repeat (2) @(posedge clk);
         #1;
         chk("reset_out_valid", out_valid, 0);
         chk("reset_busy", busy, 0);
         chk("reset_done", done, 0);
         chk("reset_nb_idx", out_nb_idx, 0);
         chk("reset_position", out_position[NC-1], 0);
         chk("reset_wrap", out_wrap[0], 0);
         rst = 1'b0;
         @(posedge clk);
         #1;
      endtask

      task automatic run_sweep(input bit full, input bit idx_pos, input int restart_at, input int rst_at, input bit start_at_done);
         int cyc, d0, vcyc;
         for (int h = 0; h < NC; h++) rd_pos[h] = idx_pos ? 30'(h) : 30'($urandom);
         push_sweep(full);
         d0 = done_cnt; beats_seen = 0;
         start = 1'b1; full_shell = full;
         @(posedge clk);
         #1;
         start = 1'b0;
         chk("first_beat_valid", out_valid, 1);
         chk("first_beat_idx", out_nb_idx, 0);
         chk("busy_after_start", busy, 1);
         cyc = 0; vcyc = 0;
         while (!done && cyc < 500) begin
            full_shell = 1'($urandom_range(0, 1));
            start = (restart_at >= 0 && beats_seen == restart_at);
            if (rst_at >= 0 && beats_seen == rst_at) begin
               rst = 1'b1;
               #1;
               chk("abort_valid_low", out_valid, 0);
               chk("abort_busy_low", busy, 0);
               chk("abort_nb_idx_zero", out_nb_idx, 0);
               chk("abort_position_zero", out_position[1], 0);
               exp_q.delete();
               @(posedge clk);
               #1;
               rst = 1'b0; start = 1'b0;
               repeat (20) @(posedge clk);
               #1;
               chk("abort_no_done", done_cnt, d0);
               return;
            end
            if (out_valid) vcyc++;
            @(posedge clk);
            #1;
            cyc++;
         end
         if (!done) begin
            errors++;
            $display("FAIL sweep_timeout: no done after %0d cycles, expected done", cyc);
         end
         start = start_at_done;
         @(posedge clk);
         #1;
         start = 1'b0;
         repeat (3) @(posedge clk);
         #1;
         chk("idle_after_done_busy", busy, 0);
         chk("idle_after_done_valid", out_valid, 0);
         chk("one_done_per_sweep", done_cnt - d0, 1);
         chk("queue_drained", exp_q.size(), 0);
         chk("beats_accepted", beats_seen, full ? 27 : 14);
         if (ready_mode == 0) chk("consecutive_valid_cycles", vcyc, full ? 27 : 14);
      endtask

      always @(negedge clk) begin
         if (rst) begin
            held_v = 0; done_due = 0;
         end else begin
            if (done_due || done) begin
               chk("done_after_last_accept", done, done_due);
               if (done) chk("busy_low_with_done", busy, 0);
            end
            if (done) done_cnt++;
            done_due = 0;
            if (held_v && out_valid) begin
               same = (out_nb_idx == held_idx);
               for (int h = 0; h < NC; h++)
                  if (out_position[h] != held_pos[h] || out_wrap[h] != held_wrap[h]) same = 0;
               chk("held_beat_stable", same, 1);
            end
            held_v = out_valid && !out_ready;
            held_idx = out_nb_idx;
            for (int h = 0; h < NC; h++) begin held_pos[h] = out_position[h]; held_wrap[h] = out_wrap[h]; end
            if (out_valid && out_ready) begin
               for (int h = 0; h < NC; h++) begin
                  if (exp_q.size() == 0) begin
                     if (h == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_beat: nb_idx %0d accepted, expected no beat", out_nb_idx);
                     end
                  end else begin
                     e = exp_q.pop_front();
                     chk($sformatf("beat_n%0d_cell%0d", e[37:33], h), {out_nb_idx, out_position[h], out_wrap[h]}, e);
                  end
               end
               beats_seen++;
               if (exp_q.size() == 0) done_due = 1;
            end
         end
      end

      if (g == 0) begin : g_seq
         always @(negedge clk) begin
            if (directed && !rst && out_valid && out_ready) begin
               if (out_nb_idx == 5'd1) begin
                  chk("cell3_beat1_position", out_position[3], 0);
                  chk("cell3_beat1_wrap", out_wrap[3], 3'b001);
               end
               if (out_nb_idx == 5'd5) begin
                  chk("cell0_beat5_position", out_position[0], 31);
                  chk("cell0_beat5_wrap", out_wrap[0], 3'b011);
               end
            end
         end
         initial begin
            wait (phase == 0);
            reset_check();
            ready_mode = 0; directed = 1;
            run_sweep(0, 1, -1, -1, 0);
            directed = 0; ready_mode = 1;
            run_sweep(0, 0, -1, -1, 0);
            ready_mode = 2;
            run_sweep(0, 0, 7, -1, 0);
            run_sweep(1, 0, -1, 5, 0);
            run_sweep(0, 0, -1, -1, 0);
            phase = 1;
         end
      end else if (g == 1) begin : g_seq
         always @(negedge clk) begin
            if (directed && !rst && out_valid && out_ready && out_nb_idx == 5'd1) begin
               chk("full_cell0_beat1_position", out_position[0], 26);
               chk("full_cell0_beat1_wrap", out_wrap[0], 3'b111);
            end
         end
         initial begin
            wait (phase == 1);
            reset_check();
            ready_mode = 0; directed = 1;
            run_sweep(1, 1, -1, -1, 1);
            directed = 0; ready_mode = 2;
            run_sweep(1, 0, -1, -1, 0);
            phase = 2;
         end
      end else begin : g_seq
         initial begin
            wait (phase == 2);
            reset_check();
            ready_mode = 2;
            run_sweep(1, 0, -1, -1, 0);
            run_sweep(0, 0, 3, -1, 1);
            ready_mode = 0;
            run_sweep(1, 0, -1, -1, 0);
            phase = 3;
         end
      end
   end

   initial begin
      for (int c = 0; c < 60000 && phase < 3; c++) @(posedge clk);
      if (phase < 3) begin
         errors++;
         $display("FAIL run_timeout: phase %0d, expected 3", phase);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/position_neighbor_streamer.md
POSITION_NEIGHBOR_STREAMER -- requirements
Module: position_neighbor_streamer

Interface
REQ-001 SHALL have parameter X_DIM, default 4, meaning cells along x (legal range 3..16).
REQ-002 SHALL have parameter Y_DIM, default 4, meaning cells along y (legal range 3..16).
REQ-003 SHALL have parameter Z_DIM, default 4, meaning cells along z (legal range 3..16).
REQ-004 SHALL have parameter NUM_CELLS, default X_DIM*Y_DIM*Z_DIM, meaning home-cell count; any other value SHALL be an elaboration error.
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port start, input, 1 bit: request one neighbor sweep.
REQ-008 SHALL have port full_shell, input, 1 bit: mode (0 = half shell, 14 beats; 1 = full shell, 27 beats), sampled only on an accepted start.
REQ-009 SHALL have port rd_nb_position, input, offset_tuple_t[NUM_CELLS]: per-cell position-cache readouts, which upstream holds stable while busy=1.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream PE array accepts the current beat.
REQ-011 SHALL have port out_valid, output, 1 bit: the current beat is valid.
REQ-012 SHALL have port out_position, output, offset_tuple_t[NUM_CELLS]: for each home cell, the position of its neighbor n.
REQ-013 SHALL have port out_nb_idx, output, 5 bits: neighbor index n of the current beat.
REQ-014 SHALL have port out_wrap, output, [NUM_CELLS][2:0]: per-cell flags {z,y,x}, set where the neighbor crosses a periodic boundary.
REQ-015 SHALL have port busy, output, 1 bit: a sweep is in progress.
REQ-016 SHALL have port done, output, 1 bit: one-cycle pulse on sweep completion.

Function
REQ-017 Home cell h SHALL be h = z*X_DIM*Y_DIM + y*X_DIM + x; neighbor (dx,dy,dz) SHALL be cell ((x+dx) mod X_DIM, (y+dy) mod Y_DIM, (z+dz) mod Z_DIM).
REQ-018 out_wrap bit d SHALL be set when coordinate d wraps (x+dx<0 or x+dx≥X_DIM; likewise for y and z).
REQ-019 Half-shell order for n=0..13 SHALL be (dx,dy,dz): (0,0,0),(1,0,0),(-1,1,0),(0,1,0),(1,1,0),(-1,-1,1),(0,-1,1),(1,-1,1),(-1,0,1),(0,0,1),(1,0,1),(-1,1,1),(0,1,1),(1,1,1).
REQ-020 Full-shell order SHALL be n=0 (0,0,0), then n=1..26 the remaining offsets in lexicographic (dz,dy,dx) order from (-1,-1,-1) to (1,1,1).
REQ-021 The FSM SHALL have states IDLE, RUN and DRAIN.
REQ-022 In IDLE, start=1 SHALL capture full_shell, clear the counter n to 0, and move to RUN; busy SHALL be 1 from the next cycle.
REQ-023 In RUN, the output register SHALL load beat n when out_valid=0 or out_ready=1, then n SHALL increment.
REQ-024 The first beat SHALL appear with out_valid=1 exactly one cycle after start (latency 1).
REQ-025 When the last beat (13 in half mode, 26 in full mode) is loaded, the FSM SHALL move to DRAIN.
REQ-026 In DRAIN, the FSM SHALL hold until the last beat is accepted (out_valid & out_ready); it SHALL then pulse done=1 and return to IDLE, and busy SHALL be 0 in that same cycle.
REQ-027 When out_valid=1 and out_ready=0, out_position, out_nb_idx and out_wrap SHALL hold stable.
REQ-028 start SHALL be ignored while busy=1; full_shell changes mid-sweep SHALL have no effect.
REQ-029 With out_ready held at 1, a sweep SHALL take 14 (half) or 27 (full) consecutive valid cycles, followed by done on the cycle after the last accept.
REQ-030 A start asserted in the same cycle as done SHALL be ignored; a new sweep SHALL begin only from IDLE.
REQ-031 All outputs SHALL be registered.

Reset
REQ-032 On rst=1, asynchronously: state=IDLE, n=0, out_valid=0, busy=0, done=0, out_nb_idx=0, out_position=0, out_wrap=0.
REQ-033 Reset mid-sweep SHALL abort the sweep with no done pulse; the first start after rst deassertion SHALL behave normally.

Verification
REQ-034 Half sweep, 4x4x4, out_ready=1, cell positions = cell index: cell 3 (x=3,y=0,z=0) beat 1 -> position 0, wrap=001; beat 5 for cell 0 -> position 31 (x=3,y=3,z=1), wrap=011.
REQ-035 Full sweep, 3x3x3: cell 0, beat 1 (-1,-1,-1) -> cell 26, wrap=111; 27 valid beats, then done.
REQ-036 Backpressure with out_ready toggling 1,0,0,1 during a half sweep: held beats unchanged, out_nb_idx sequence 0..13 with no gaps or duplicates.
REQ-037 start asserted at beat 7 of a running sweep -> ignored, exactly one done.
REQ-038 rst pulsed at beat 5 -> out_valid=0 and busy=0 immediately, no done; a following start yields a clean beat 0.
REQ-039 5x3x4 asymmetric grid, full sweep: every (cell, n) is checked against a reference model using the mod rule.
